// File: rtl/pht_ctrl.sv
// Controller for the 2-bit pattern-history-table SRAM. Port 0 serves prediction lookups.
// Port 1 runs the reset-time init sweep and the read-modify-write counter updates.
module pht_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter int unsigned           DATA_WIDTH = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    output logic                  pred_ready,
    input  logic [ADDR_WIDTH-1:0] pred_idx,
    output logic                  pred_rsp_valid,
    output logic [DATA_WIDTH-1:0] pred_ctr,
    output logic                  pred_taken,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_idx,
    input  logic                  upd_taken,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic                  web1,
    output logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam int unsigned           RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  tkn_q;
    logic                  fwd_valid_q;
    logic [ADDR_WIDTH-1:0] fwd_idx_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic [ADDR_WIDTH-1:0] pidx_q;
    logic                  pred_rsp_valid_q;
    logic                  init_done_q;

    logic                  port1_en_s;
    logic                  pred_fire_s;
    logic                  fwd_hit_s;
    logic [DATA_WIDTH-1:0] wr_data_s;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic [DATA_WIDTH-1:0] ctr,
                                                  input logic                  taken);
        logic [DATA_WIDTH-1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? ctr : ctr - 2'b01;
        end
        return res;
    endfunction

    // Handshakes, port 0 lookup and the prediction response mux.
    always_comb begin
        pred_ready     = ~rst & (state_q != S_INIT);
        upd_ready      = ~rst & ((state_q == S_IDLE) | (state_q == S_WR));
        pred_fire_s    = pred_valid & pred_ready;
        csb0           = ~pred_fire_s;
        web0           = 1'b1;
        addr0          = pred_idx;
        din0           = {DATA_WIDTH{1'b0}};
        wr_data_s      = sat(dout1, tkn_q);
        // A write latched on the acceptance edge is not yet in the array, so bypass it.
        fwd_hit_s      = fwd_valid_q & (fwd_idx_q == pidx_q);
        pred_rsp_valid = pred_rsp_valid_q;
        pred_ctr       = pred_rsp_valid_q ? (fwd_hit_s ? fwd_data_q : dout0) : {DATA_WIDTH{1'b0}};
        pred_taken     = pred_ctr[1];
        init_done      = init_done_q;
    end

    // Port 1 command decode from the update FSM state.
    always_comb begin
        port1_en_s = 1'b0;
        web1       = 1'b1;
        addr1      = idx_q;
        din1       = {DATA_WIDTH{1'b0}};
        case (state_q)
            S_INIT: begin
                port1_en_s = 1'b1;
                web1       = 1'b0;
                addr1      = init_cnt_q;
                din1       = INIT_VAL;
            end
            S_RD: begin
                port1_en_s = 1'b1;
            end
            S_WR: begin
                port1_en_s = 1'b1;
                web1       = 1'b0;
                din1       = wr_data_s;
            end
            default: begin
                port1_en_s = 1'b0;
            end
        endcase
        csb1 = rst | ~port1_en_s;
    end

    // Update FSM, init sweep, forwarding and prediction response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_INIT;
            init_cnt_q       <= {ADDR_WIDTH{1'b0}};
            idx_q            <= {ADDR_WIDTH{1'b0}};
            tkn_q            <= 1'b0;
            fwd_valid_q      <= 1'b0;
            fwd_idx_q        <= {ADDR_WIDTH{1'b0}};
            fwd_data_q       <= {DATA_WIDTH{1'b0}};
            pidx_q           <= {ADDR_WIDTH{1'b0}};
            pred_rsp_valid_q <= 1'b0;
            init_done_q      <= 1'b0;
        end else begin
            pred_rsp_valid_q <= pred_fire_s;
            if (pred_fire_s) begin
                pidx_q <= pred_idx;
            end
            fwd_valid_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    if (init_cnt_q == LAST_IDX) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (upd_valid) begin
                        idx_q   <= upd_idx;
                        tkn_q   <= upd_taken;
                        state_q <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_WR;
                end
                S_WR: begin
                    fwd_valid_q <= 1'b1;
                    fwd_idx_q   <= idx_q;
                    fwd_data_q  <= wr_data_s;
                    if (upd_valid) begin
                        idx_q   <= upd_idx;
                        tkn_q   <= upd_taken;
                        state_q <= S_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pht_ctrl.sv
// Bench for pht_ctrl: behavioural SRAM, high-level table model, scoreboard of predictions
// and per-cycle handshake checks, with directed scenarios followed by random traffic.
module tb_pht_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pred_valid, pred_ready, pred_rsp_valid, pred_taken;
    logic [3:0] pred_idx;
    logic [1:0] pred_ctr;
    logic       upd_valid, upd_ready, upd_taken, init_done;
    logic [3:0] upd_idx;
    logic       csb0, web0, csb1, web1;
    logic [3:0] addr0, addr1;
    logic [1:0] din0, dout0, din1, dout1;

    pht_ctrl dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_idx(pred_idx),
        .pred_rsp_valid(pred_rsp_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .init_done(init_done),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .csb1(csb1), .web1(web1), .addr1(addr1), .din1(din1), .dout1(dout1)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port SRAM: latch on csb low, write commits next edge.
    logic [1:0] mem [16];
    logic [3:0] a0_q, a1_q, wa_q;
    logic [1:0] wd_q;
    logic       wpend_q = 1'b0;
    logic       stale_done = 1'b0;
    always @(posedge clk) begin
        if (!stale_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 2'b10;
            stale_done <= 1'b1;
        end else if (wpend_q) begin
            mem[wa_q] <= wd_q;
        end
        if (!csb0) a0_q <= addr0;
        if (!csb1) begin
            a1_q    <= addr1;
            wa_q    <= addr1;
            wd_q    <= din1;
            wpend_q <= !web1;
        end else begin
            wpend_q <= 1'b0;
        end
    end
    assign dout0 = mem[a0_q];
    assign dout1 = mem[a1_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct { logic [3:0] idx; logic tkn; int due; } upd_t;
    typedef struct { logic [1:0] ctr; int due; } exp_t;
    upd_t pend_q[$];
    exp_t exp_q[$];
    int   model_tab [16];
    int   init_rem = 16;
    int   last_upd_edge = -10;

    // Reference model: decides what the upcoming edge accepts and what a lookup must return.
    always @(negedge clk) begin
        int edge_n;
        edge_n = cyc + 1;
        check("pred_ready", pred_ready, (!rst && init_rem == 0));
        check("upd_ready", upd_ready, (!rst && init_rem == 0 && last_upd_edge != edge_n - 1));
        if (rst) begin
            pend_q.delete();
            for (int i = 0; i < 16; i++) model_tab[i] = 1;
            init_rem      = 16;
            last_upd_edge = -10;
        end else begin
            if (init_rem > 0) init_rem--;
            while (pend_q.size() > 0 && pend_q[0].due <= edge_n) begin
                upd_t u;
                u = pend_q.pop_front();
                if (u.tkn) model_tab[u.idx] = (model_tab[u.idx] < 3) ? model_tab[u.idx] + 1 : 3;
                else       model_tab[u.idx] = (model_tab[u.idx] > 0) ? model_tab[u.idx] - 1 : 0;
            end
            if (pred_valid && pred_ready) begin
                exp_t e;
                e.ctr = 2'(model_tab[pred_idx]);
                e.due = edge_n;
                exp_q.push_back(e);
            end
            if (upd_valid && upd_ready) begin
                upd_t u;
                u.idx = upd_idx;
                u.tkn = upd_taken;
                u.due = edge_n + 2;
                pend_q.push_back(u);
                last_upd_edge = edge_n;
            end
        end
    end

    logic [1:0] last_ctr = 2'b00;
    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (pred_rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_latency", cyc, e.due);
                check("pred_ctr", pred_ctr, e.ctr);
                check("pred_taken", pred_taken, e.ctr[1]);
            end
            last_ctr <= pred_ctr;
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            void'(exp_q.pop_front());
            check("missing_rsp", 0, 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [3:0] idx, input logic tkn);
        bit ok = 0;
        upd_valid = 1'b1; upd_idx = idx; upd_taken = tkn;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (upd_ready) begin ok = 1; break; end
        end
        if (!ok) check("upd_timeout", 0, 1);
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_pred(input logic [3:0] idx);
        bit ok = 0;
        pred_valid = 1'b1; pred_idx = idx;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (pred_ready) begin ok = 1; break; end
        end
        if (!ok) check("pred_timeout", 0, 1);
        @(posedge clk); #1;
        pred_valid = 1'b0;
    endtask

    task automatic pred_expect(input string name, input logic [3:0] idx, input logic [1:0] exp);
        do_pred(idx);
        tick(2);
        check(name, last_ctr, exp);
    endtask

    initial begin
        int acc [2];
        int nacc;
        rst = 1'b1; pred_valid = 1'b1; pred_idx = 4'd0;
        upd_valid = 1'b0; upd_idx = 4'd0; upd_taken = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_csb0", csb0, 1);
            check("rst_csb1", csb1, 1);
        end
        @(posedge clk); #1;
        rst = 1'b0; pred_valid = 1'b0;
        check("rst_rsp_valid", pred_rsp_valid, 0);
        check("rst_pred_ctr", pred_ctr, 0);
        // Init sweep: one write of 01 per address, in order.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("init_wr", {csb1, web1, addr1, din1}, {1'b0, 1'b0, 4'(k), 2'b01});
            check("init_done_low", init_done, 0);
        end
        @(negedge clk);
        check("init_done_high", init_done, 1);
        tick(1);

        pred_expect("pred5_init", 4'd5, 2'b01);
        check("pred5_taken", pred_taken, 0);

        repeat (3) begin do_upd(4'd3, 1'b1); tick(3); end
        pred_expect("idx3_sat_hi", 4'd3, 2'b11);
        do_upd(4'd3, 1'b1); tick(3);
        pred_expect("idx3_stay_hi", 4'd3, 2'b11);
        repeat (3) begin do_upd(4'd3, 1'b0); tick(3); end
        pred_expect("idx3_sat_lo", 4'd3, 2'b00);
        do_upd(4'd3, 1'b0); tick(3);
        pred_expect("idx3_stay_lo", 4'd3, 2'b00);

        // upd_valid held high: two acceptances two cycles apart.
        upd_valid = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1; nacc = 0;
        for (int t = 0; t < 40 && nacc < 2; t++) begin
            @(negedge clk);
            if (upd_ready) begin acc[nacc] = cyc + 1; nacc++; end
        end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        check("b2b_count", nacc, 2);
        check("b2b_spacing", acc[1] - acc[0], 2);
        tick(3);
        pred_expect("idx7_b2b", 4'd7, 2'b11);

        // Prediction accepted on the WR-closing edge sees the update via forwarding.
        do_upd(4'd9, 1'b1);
        tick(1);
        pred_valid = 1'b1; pred_idx = 4'd9;
        tick(1);
        pred_valid = 1'b0;
        tick(2);
        check("fwd_idx9", last_ctr, 2'b10);
        do_upd(4'd9, 1'b0); tick(3);
        // Prediction accepted during RD returns the pre-update value.
        do_upd(4'd9, 1'b1);
        pred_valid = 1'b1; pred_idx = 4'd9;
        tick(1);
        pred_valid = 1'b0;
        tick(2);
        check("rd_idx9", last_ctr, 2'b01);
        tick(2);

        // Reset during the WR cycle of an update.
        do_upd(4'd4, 1'b1);
        pred_valid = 1'b1; pred_idx = 4'd4;
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        check("rstwr_csb1", csb1, 1);
        @(posedge clk); #1;
        rst = 1'b0; pred_valid = 1'b0;
        @(negedge clk);
        check("rstwr_rsp_valid", pred_rsp_valid, 0);
        tick(20);
        for (int i = 0; i < 16; i++) begin
            pred_valid = 1'b1; pred_idx = 4'(i);
            tick(1);
        end
        pred_valid = 1'b0;
        tick(2);
        check("reinit_last", last_ctr, 2'b01);

        // Random concurrent traffic.
        for (int n = 0; n < 400; n++) begin
            pred_valid = 1'($urandom_range(0, 1));
            pred_idx   = 4'($urandom_range(0, 15));
            upd_valid  = 1'($urandom_range(0, 1));
            upd_idx    = 4'($urandom_range(0, 3));
            upd_taken  = 1'($urandom_range(0, 1));
            tick(1);
        end
        pred_valid = 1'b0; upd_valid = 1'b0;
        tick(6);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
